// File: rtl/ffd_capture.sv
// Tap-bus sampler: SYNC_STAGES-deep synchroniser feeding a one-shot capture buffer
// that fills DEPTH consecutive samples on arm, then drains them over a valid/ready port.
module ffd_capture #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 8
) (
  input  logic                       c,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           q,
  output logic [WIDTH-1:0]           d,
  input  logic                       arm,
  output logic                       busy,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [$clog2(DEPTH)-1:0]   rd_idx
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  // Synchroniser chain must survive synthesis untouched: no retiming, no merging.
  (* dont_touch = "true" *) logic [WIDTH-1:0] sync_p [SYNC_STAGES];

  logic [1:0]       state;
  logic [AW-1:0]    wr_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             xfer;

  // Stage boundary: q -> sync_p[0] -> ... -> sync_p[SYNC_STAGES-1] = d
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
    end else begin
      sync_p[0] <= q;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
    end
  end

  assign d = sync_p[SYNC_STAGES-1];

  assign busy     = (state == FILL) || (state == DRAIN);
  assign rd_valid = (state == DRAIN);
  assign rd_data  = mem[rd_idx];
  assign xfer     = rd_valid && rd_ready;

  // Stage boundary: capture buffer write (contents deliberately unreset)
  always_ff @(posedge c) begin
    if (state == FILL) mem[wr_ptr] <= d;
  end

  // Stage boundary: control FSM
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            state  <= FILL;
            wr_ptr <= '0;
          end
        end
        FILL: begin
          wr_ptr <= wr_ptr + 1'b1;
          if (wr_ptr == LAST_IDX) begin
            state  <= DRAIN;
            rd_idx <= '0;
          end
        end
        DRAIN: begin
          if (xfer) begin
            rd_idx <= rd_idx + 1'b1;
            if (rd_idx == LAST_IDX) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ffd_capture.sv
// Directed bench for ffd_capture: default instance (16/2/8) plus a minimal one (1/4/2).
module tb_ffd_capture;

  logic        c;
  logic        rst_n;
  logic [15:0] q;
  logic [15:0] d;
  logic        arm;
  logic        busy;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [2:0]  rd_idx;

  logic [0:0]  q1;
  logic [0:0]  d1;
  logic        arm1;
  logic        busy1;
  logic [0:0]  rd_data1;
  logic        rd_valid1;
  logic        rd_ready1;
  logic [0:0]  rd_idx1;

  int n_chk  = 0;
  int n_fail = 0;
  bit ramp   = 0;

  ffd_capture #(.WIDTH(16), .SYNC_STAGES(2), .DEPTH(8)) dut (
    .c(c), .rst_n(rst_n), .q(q), .d(d), .arm(arm), .busy(busy),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_idx(rd_idx)
  );

  ffd_capture #(.WIDTH(1), .SYNC_STAGES(4), .DEPTH(2)) dut1 (
    .c(c), .rst_n(rst_n), .q(q1), .d(d1), .arm(arm1), .busy(busy1),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .rd_ready(rd_ready1), .rd_idx(rd_idx1)
  );

  initial begin
    c = 1'b0;
    forever #5 c = ~c;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] q;
    logic [15:0] exp_d;
    logic        q1;
    logic        exp_d1;
  } lat_vec_t;

  lat_vec_t lat_tab [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge c);
    if (ramp) q = q + 16'd1;
  endtask

  task automatic wait_valid(input int max_cyc);
    int n = 0;
    while (!rd_valid && n < max_cyc) begin
      tick();
      n++;
    end
    chk("wait_valid", 64'(rd_valid), 64'd1);
  endtask

  // Ramp q so it reads 0x0010 on the arm cycle; the first sample written is then 0x000F.
  task automatic start_burst(input bit hold);
    q = 16'h000D;
    ramp = 1;
    tick(); tick(); tick();
    arm = 1'b1;
    tick();
    if (!hold) arm = 1'b0;
  endtask

  task automatic drain_expect(input int first, input int last, input logic [15:0] base);
    for (int k = first; k <= last; k++) begin
      chk("drain_valid", 64'(rd_valid), 64'd1);
      chk("drain_idx",   64'(rd_idx),   64'(k));
      chk("drain_data",  64'(rd_data),  64'(base + 16'(k)));
      tick();
    end
  endtask

  initial begin
    bit seen;
    int n;

    lat_tab[0] = '{16'h0000, 16'h0000, 1'b1, 1'b0};
    lat_tab[1] = '{16'hA5A5, 16'h0000, 1'b0, 1'b0};
    lat_tab[2] = '{16'hA5A5, 16'hA5A5, 1'b0, 1'b0};
    lat_tab[3] = '{16'h5A5A, 16'hA5A5, 1'b1, 1'b1};
    lat_tab[4] = '{16'hFFFF, 16'h5A5A, 1'b1, 1'b0};
    lat_tab[5] = '{16'h0001, 16'hFFFF, 1'b0, 1'b0};
    lat_tab[6] = '{16'h0001, 16'h0001, 1'b0, 1'b1};
    lat_tab[7] = '{16'h8000, 16'h0001, 1'b1, 1'b1};
    lat_tab[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0};
    lat_tab[9] = '{16'h0000, 16'h8000, 1'b0, 1'b0};

    rst_n = 1'b0; q = 16'h1234; arm = 1'b0; rd_ready = 1'b1;
    q1 = 1'b1; arm1 = 1'b0; rd_ready1 = 1'b1;
    repeat (2) @(negedge c);
    chk("rst_d",        64'(d),        64'd0);
    chk("rst_busy",     64'(busy),     64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_idx",   64'(rd_idx),   64'd0);
    chk("rst_d1",       64'(d1),       64'd0);
    chk("rst_busy1",    64'(busy1),    64'd0);
    rst_n = 1'b1;
    q = 16'h0000; q1 = 1'b0;
    repeat (5) tick();

    // Synchroniser latency, both instances, from the vector table
    for (int i = 0; i < 10; i++) begin
      q  = lat_tab[i].q;
      q1 = lat_tab[i].q1;
      tick();
      chk("lat_d",  64'(d),  64'(lat_tab[i].exp_d));
      chk("lat_d1", 64'(d1), 64'(lat_tab[i].exp_d1));
    end
    chk("idle_busy", 64'(busy), 64'd0);

    // Basic burst
    start_burst(1'b0);
    chk("fill_busy",     64'(busy),     64'd1);
    chk("fill_rd_valid", 64'(rd_valid), 64'd0);
    wait_valid(20);
    drain_expect(0, 7, 16'h000F);
    chk("burst_end_valid", 64'(rd_valid), 64'd0);
    chk("burst_end_busy",  64'(busy),     64'd0);

    // Backpressure at index 3
    start_burst(1'b0);
    wait_valid(20);
    drain_expect(0, 2, 16'h000F);
    rd_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_idx",  64'(rd_idx),  64'd3);
      chk("bp_data", 64'(rd_data), 64'h0012);
      tick();
    end
    rd_ready = 1'b1;
    drain_expect(3, 7, 16'h000F);
    chk("bp_end_busy", 64'(busy), 64'd0);

    // Arm pulses during FILL and DRAIN are ignored
    start_burst(1'b0);
    tick(); tick();
    arm = 1'b1; tick(); arm = 1'b0;
    wait_valid(20);
    drain_expect(0, 1, 16'h000F);
    arm = 1'b1;
    drain_expect(2, 2, 16'h000F);
    arm = 1'b0;
    drain_expect(3, 7, 16'h000F);
    chk("ign_end_valid", 64'(rd_valid), 64'd0);
    repeat (3) begin
      tick();
      chk("ign_no_queue", 64'(busy), 64'd0);
    end

    // Arm held high: new burst on the first IDLE edge
    start_burst(1'b1);
    wait_valid(20);
    drain_expect(0, 7, 16'h000F);
    chk("hold_idle_busy",  64'(busy),     64'd0);
    chk("hold_idle_valid", 64'(rd_valid), 64'd0);
    tick();
    chk("hold_refill_busy", 64'(busy), 64'd1);
    arm = 1'b0;
    wait_valid(20);
    drain_expect(0, 7, 16'h0020);
    chk("hold_end_busy", 64'(busy), 64'd0);

    // Reset asserted mid-DRAIN at index 5
    q1 = 1'b1;
    start_burst(1'b0);
    wait_valid(20);
    drain_expect(0, 4, 16'h000F);
    chk("mid_idx", 64'(rd_idx), 64'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(rd_valid), 64'd0);
    chk("mid_rst_busy",  64'(busy),     64'd0);
    chk("mid_rst_d",     64'(d),        64'd0);
    chk("mid_rst_idx",   64'(rd_idx),   64'd0);
    chk("mid_rst_d1",    64'(d1),       64'd0);
    @(negedge c);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (rd_valid || busy) seen = 1'b1;
    end
    chk("mid_no_activity", 64'(seen), 64'd0);
    ramp = 0;

    // Minimal instance: exactly two transfers per burst
    arm1 = 1'b1; tick(); arm1 = 1'b0;
    chk("p_busy1", 64'(busy1), 64'd1);
    n = 0;
    while (!rd_valid1 && n < 10) begin
      tick();
      n++;
    end
    for (int k = 0; k < 2; k++) begin
      chk("p_valid1", 64'(rd_valid1), 64'd1);
      chk("p_idx1",   64'(rd_idx1),   64'(k));
      chk("p_data1",  64'(rd_data1),  64'd1);
      tick();
    end
    chk("p_end_valid1", 64'(rd_valid1), 64'd0);
    chk("p_end_busy1",  64'(busy1),     64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ffd_capture.md
FFD_CAPTURE -- requirements
Module: ffd_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning sampled bus width (1..64).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning flip-flop stages from q to d (1..4).
REQ-003 SHALL have parameter DEPTH, default 8, meaning capture buffer entries (power of 2, 2..256).
REQ-004 SHALL have port c  input  1  the single clock; all flops are rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port q  input  WIDTH  asynchronous tap bus to sample, for example ring-oscillator taps.
REQ-007 SHALL have port d  output  WIDTH  q after SYNC_STAGES register stages.
REQ-008 SHALL have port arm  input  1  request to start one capture burst.
REQ-009 SHALL have port busy  output  1  high in FILL and DRAIN.
REQ-010 SHALL have port rd_data  output  WIDTH  buffer entry presented for readout.
REQ-011 SHALL have port rd_valid  output  1  rd_data holds a valid entry.
REQ-012 SHALL have port rd_ready  input  1  consumer accepts rd_data.
REQ-013 SHALL have port rd_idx  output  clog2(DEPTH)  index of the entry now presented.

Function
REQ-014 SHALL register every bit of q through SYNC_STAGES flops in series, with no logic between stages; d SHALL equal q delayed by exactly SYNC_STAGES rising edges.
REQ-015 SHALL mark every synchroniser flop as dont_touch so that synthesis neither retimes nor merges them.
REQ-016 SHALL implement the FSM states IDLE, FILL and DRAIN, and SHALL leave reset in IDLE.
REQ-017 SHALL move IDLE->FILL on an edge where arm=1, and SHALL clear wr_ptr to 0.
REQ-018 SHALL, in FILL, write d into mem[wr_ptr] on each edge and increment wr_ptr; entry k SHALL be the d value present k cycles after the first FILL cycle.
REQ-019 SHALL move FILL->DRAIN on the edge that writes entry DEPTH-1; wr_ptr SHALL wrap to 0 and SHALL never overwrite within a burst.
REQ-020 SHALL, in DRAIN, assert rd_valid and drive rd_data=mem[rd_idx], starting with rd_idx=0.
REQ-021 SHALL count a transfer on each edge where rd_valid=1 and rd_ready=1; rd_idx SHALL then increment.
REQ-022 SHALL keep rd_data and rd_idx stable while rd_valid=1 and rd_ready=0.
REQ-023 SHALL move DRAIN->IDLE on the transfer of entry DEPTH-1; rd_valid SHALL be 0 on the following cycle.
REQ-024 SHALL ignore arm in FILL and DRAIN, with no queuing; arm held high through DRAIN SHALL start a new FILL on the first IDLE edge.
REQ-025 SHALL hold busy=1 exactly when the state is FILL or DRAIN.
REQ-026 SHALL hold rd_valid=0 in IDLE and FILL; rd_data SHALL be don't-care whenever rd_valid=0.
REQ-027 SHALL keep the synchroniser running in every state, including IDLE.

Reset
REQ-028 SHALL, on rst_n=0, immediately and without a clock force the state to IDLE, all synchroniser flops to 0 (d=0), wr_ptr=0, rd_idx=0, busy=0 and rd_valid=0.
REQ-029 SHALL leave buffer contents unreset and unobservable until rewritten.
REQ-030 SHALL abandon a capture or drain in progress when reset is asserted mid-operation; after release the block SHALL wait in IDLE for a new arm.
REQ-031 SHALL resume operation on the first rising edge after rst_n deasserts.

Verification
REQ-032 Latency: SYNC_STAGES=2, q steps 0x0000->0xA5A5 at edge n -> d=0xA5A5 from edge n+2, and 0 before.
REQ-033 Burst: DEPTH=8, q incremented by 1 each cycle from 0x0010, arm pulsed one cycle -> drained entries are 8 consecutive values, each +1 from the previous, rd_idx 0..7, then busy=0.
REQ-034 Backpressure: rd_ready=0 for 5 cycles at rd_idx=3 -> rd_data and rd_idx frozen; after rd_ready=1, entries 4..7 follow with no loss or duplicate.
REQ-035 Arm ignored: arm pulsed during FILL and during DRAIN -> exactly 8 transfers, then IDLE; arm held high -> second burst starts on the first IDLE edge.
REQ-036 Reset mid-DRAIN: rst_n=0 at rd_idx=5 -> rd_valid, busy and d are 0 with no clock edge; after release, no rd_valid until the next arm.
REQ-037 Parameters: WIDTH=1, SYNC_STAGES=4, DEPTH=2 -> d latency 4, exactly 2 transfers per burst.
